// File: rtl/dot_accum_pkg.sv
// Shared widths, sideband type and saturation helper for the dot-product accumulator.
// The width helpers keep the product, tree and accumulator sizing in one place.
package dot_accum_pkg;

  typedef struct packed {
    logic valid;
    logic last;
    logic sgn;
  } beat_sb_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sat;
  } sat_t;

  function automatic int nb_prod(input int nb_data);
    return 2 * nb_data + 1;
  endfunction

  function automatic int nb_tree(input int nb_data, input int n_pairs);
    return nb_prod(nb_data) + $clog2(n_pairs);
  endfunction

  function automatic int nb_acc(input int nb_data, input int n_pairs, input int max_beats);
    return nb_tree(nb_data, n_pairs) + $clog2(max_beats);
  endfunction

  // Number of live nodes at tree level l when the tree starts with n leaves.
  function automatic int lvl_cnt(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  // Clamp a signed value into the NB_OUT-bit signed or unsigned range.
  function automatic sat_t saturate(input longint value, input logic is_signed, input int nb_out);
    longint hi;
    longint lo;
    sat_t   r;
    hi = is_signed ? ((longint'(1) <<< (nb_out - 1)) - 1) : ((longint'(1) <<< nb_out) - 1);
    lo = is_signed ? -(longint'(1) <<< (nb_out - 1)) : longint'(0);
    r.sat  = 1'b0;
    r.data = value;
    if (value > hi) begin
      r.data = hi;
      r.sat  = 1'b1;
    end else if (value < lo) begin
      r.data = lo;
      r.sat  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// Registered binary adder tree over N_IN signed inputs; an unpaired node at an odd
// level is registered unchanged so every path has the same depth.
module pipelined_adder_tree
  import dot_accum_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int NB_IN = 17
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_IN*NB_IN-1:0]                i_data,
  input  beat_sb_t                             i_sb,
  output logic signed [NB_IN+$clog2(N_IN)-1:0] o_sum,
  output beat_sb_t                             o_sb
);

  localparam int T    = $clog2(N_IN);
  localparam int NB_O = NB_IN + T;

  // One spare column so the pairing index never runs past the array.
  logic signed [NB_O-1:0] node [T+1][N_IN+1];

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign node[0][i] = NB_O'(signed'(i_data[i*NB_IN +: NB_IN]));
  end
  assign node[0][N_IN] = '0;

  for (genvar l = 1; l <= T; l++) begin : g_lvl
    localparam int N_PREV = lvl_cnt(N_IN, l - 1);
    localparam int N_CUR  = lvl_cnt(N_IN, l);

    logic signed [NB_O-1:0] sum_d [N_CUR];
    logic signed [NB_O-1:0] sum_q [N_CUR];

    // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch is inferred.
    always_comb begin
      for (int k = 0; k < N_CUR; k++) begin
        if (2 * k + 1 < N_PREV) sum_d[k] = node[l-1][2*k] + node[l-1][2*k+1];
        else                    sum_d[k] = node[l-1][2*k];
      end
    end

    // NOTE: datapath registers carry no reset; only the valid bits qualify them.
    always_ff @(posedge clock) begin
      sum_q <= sum_d;
    end

    for (genvar k = 0; k <= N_IN; k++) begin : g_node
      if (k < N_CUR) begin : g_live
        assign node[l][k] = sum_q[k];
      end else begin : g_dead
        assign node[l][k] = '0;
      end
    end
  end

  assign o_sum = node[T][0];

  if (T == 0) begin : g_sb_pass
    assign o_sb = i_sb;
  end else begin : g_sb_pipe
    beat_sb_t sb_d [T];
    beat_sb_t sb_q [T];

    always_comb begin
      sb_d[0] = i_sb;
      for (int j = 1; j < T; j++) sb_d[j] = sb_q[j-1];
    end

    // NOTE: sequential state is updated with non-blocking '<=' so all flops sample together.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int j = 0; j < T; j++) sb_q[j].valid <= 1'b0;
      end else begin
        sb_q <= sb_d;
      end
    end

    assign o_sb = sb_q[T-1];
  end

endmodule

// File: rtl/dot_accum_pipe.sv
// Pipelined dot-product accumulator: pairwise products, registered adder tree,
// then a framed accumulator with saturated, registered result outputs.
module dot_accum_pipe
  import dot_accum_pkg::*;
#(
  parameter int N_PAIRS   = 4,
  parameter int NB_DATA   = 8,
  parameter int MAX_BEATS = 16,
  parameter int NB_OUT    = 24
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [2*N_PAIRS*NB_DATA-1:0]   i_data,
  input  logic                           i_valid,
  input  logic                           i_last,
  input  logic                           i_signed,
  output logic [NB_OUT-1:0]              o_data,
  output logic                           o_valid,
  output logic                           o_sat,
  output logic                           o_trunc
);

  localparam int NB_PROD = nb_prod(NB_DATA);
  localparam int NB_TREE = nb_tree(NB_DATA, N_PAIRS);
  localparam int NB_ACC  = nb_acc(NB_DATA, N_PAIRS, MAX_BEATS);
  localparam int CNT_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  // Operands widened by one bit so signed and unsigned products share one multiplier.
  logic signed [NB_DATA:0]       op_a [N_PAIRS];
  logic signed [NB_DATA:0]       op_b [N_PAIRS];
  logic signed [2*NB_DATA+1:0]   full [N_PAIRS];
  logic [N_PAIRS*NB_PROD-1:0]    prod_d, prod_q;
  beat_sb_t                      p_sb_d, p_sb_q;

  always_comb begin
    prod_d = '0;
    for (int k = 0; k < N_PAIRS; k++) begin
      op_a[k] = {i_signed & i_data[2*k*NB_DATA + NB_DATA-1], i_data[2*k*NB_DATA +: NB_DATA]};
      op_b[k] = {i_signed & i_data[(2*k+1)*NB_DATA + NB_DATA-1], i_data[(2*k+1)*NB_DATA +: NB_DATA]};
      full[k] = op_a[k] * op_b[k];
      prod_d[k*NB_PROD +: NB_PROD] = full[k][NB_PROD-1:0];
    end
    p_sb_d = '{valid: i_valid, last: i_last, sgn: i_signed};
  end

  always_ff @(posedge clock) begin
    prod_q <= prod_d;
  end

  logic signed [NB_TREE-1:0] tree_sum;
  beat_sb_t                  tree_sb;

  pipelined_adder_tree #(
    .N_IN  (N_PAIRS),
    .NB_IN (NB_PROD)
  ) u_tree (
    .clock  (clock),
    .reset  (reset),
    .i_data (prod_q),
    .i_sb   (p_sb_q),
    .o_sum  (tree_sum),
    .o_sb   (tree_sb)
  );

  logic signed [NB_ACC-1:0] acc_d, acc_q, acc_nxt;
  logic [CNT_W-1:0]         cnt_d, cnt_q;
  logic                     first_d, first_q;
  logic                     mode_d, mode_q, mode_now;
  logic [NB_OUT-1:0]        o_data_d, o_data_q;
  logic                     o_valid_d, o_valid_q;
  logic                     o_sat_d, o_sat_q;
  logic                     o_trunc_d, o_trunc_q;
  sat_t                     sat_res;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    mode_d    = mode_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    o_sat_d   = o_sat_q;
    o_trunc_d = o_trunc_q;
    mode_now  = first_q ? tree_sb.sgn : mode_q;
    acc_nxt   = first_q ? NB_ACC'(tree_sum) : acc_q + NB_ACC'(tree_sum);
    sat_res   = saturate(longint'(acc_nxt), mode_now, NB_OUT);
    if (tree_sb.valid) begin
      acc_d  = acc_nxt;
      mode_d = mode_now;
      if (tree_sb.last || cnt_q == CNT_W'(MAX_BEATS - 1)) begin
        cnt_d     = '0;
        first_d   = 1'b1;
        o_valid_d = 1'b1;
        o_data_d  = sat_res.data[NB_OUT-1:0];
        o_sat_d   = sat_res.sat;
        o_trunc_d = ~tree_sb.last;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_sb_q.valid <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b1;
      mode_q       <= 1'b0;
      o_data_q     <= '0;
      o_valid_q    <= 1'b0;
      o_sat_q      <= 1'b0;
      o_trunc_q    <= 1'b0;
    end else begin
      p_sb_q    <= p_sb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      mode_q    <= mode_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_sat_q   <= o_sat_d;
      o_trunc_q <= o_trunc_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_sat   = o_sat_q;
  assign o_trunc = o_trunc_q;

endmodule

// File: tb/tb_dot_accum_pipe.sv
// Directed bench for dot_accum_pipe with N_PAIRS=3, NB_DATA=8, NB_OUT=16, MAX_BEATS=4.
// Completed frames are collected into queues and compared against hand-computed values.
module tb_dot_accum_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        i_signed = 1'b0;
  logic [15:0] o_data;
  logic        o_valid, o_sat, o_trunc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] q_data[$];
  logic        q_sat[$];
  logic        q_trunc[$];
  int          q_cyc[$];

  dot_accum_pipe #(
    .N_PAIRS   (3),
    .NB_DATA   (8),
    .MAX_BEATS (4),
    .NB_OUT    (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_last   (i_last),
    .i_signed (i_signed),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_sat    (o_sat),
    .o_trunc  (o_trunc)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (o_valid === 1'b1) begin
      q_data.push_back(o_data);
      q_sat.push_back(o_sat);
      q_trunc.push_back(o_trunc);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [47:0] pack6(input int a0, input int b0, input int a1,
                                        input int b1, input int a2, input int b2);
    return {8'(b2), 8'(a2), 8'(b1), 8'(a1), 8'(b0), 8'(a0)};
  endfunction

  function automatic logic [15:0] clamp_s16(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_sat.delete();
    q_trunc.delete();
    q_cyc.delete();
  endtask

  task automatic send(input logic [47:0] d, input logic last, input logic sgn, output int at);
    @(negedge clock);
    i_data   = d;
    i_valid  = 1'b1;
    i_last   = last;
    i_signed = sgn;
    at       = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (o_valid !== 1'b0)    begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_o_data: got %h want 0000", o_data); end
    checks++; if (o_sat !== 1'b0)      begin errors++; $display("FAIL reset_o_sat: got %b want 0", o_sat); end
    checks++; if (o_trunc !== 1'b0)    begin errors++; $display("FAIL reset_o_trunc: got %b want 0", o_trunc); end
    reset = 1'b0;
    clear_q();
    idle(8);
    checks++; if (q_data.size() != 0) begin errors++; $display("FAIL reset_quiet: got %0d frames want 0", q_data.size()); end
  endtask

  task automatic test_single();
    int at;
    clear_q();
    send(pack6(3, 4, -2, 5, 7, -1), 1'b1, 1'b1, at);
    idle(8);
    checks++;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d frames want 1", q_data.size());
    end else begin
      checks++; if (q_data[0] !== 16'hFFFB) begin errors++; $display("FAIL single_data: got %h want fffb", q_data[0]); end
      checks++; if (q_sat[0] !== 1'b0)      begin errors++; $display("FAIL single_sat: got %b want 0", q_sat[0]); end
      checks++; if (q_trunc[0] !== 1'b0)    begin errors++; $display("FAIL single_trunc: got %b want 0", q_trunc[0]); end
      checks++; if (q_cyc[0] != at + 4)     begin errors++; $display("FAIL single_latency: got %0d want %0d", q_cyc[0] - at, 4); end
    end
    checks++; if (o_data !== 16'hFFFB) begin errors++; $display("FAIL single_hold: got %h want fffb", o_data); end
  endtask

  task automatic test_saturation();
    int at;
    logic [15:0] exp_d [3] = '{16'h7FFF, 16'h8000, 16'hFFFF};
    clear_q();
    send(pack6(-128, -128, -128, -128, -128, -128), 1'b1, 1'b1, at);
    send(pack6(-128, 127, -128, 127, -128, 127), 1'b1, 1'b1, at);
    send(pack6(255, 255, 255, 255, 255, 255), 1'b1, 1'b0, at);
    idle(8);
    checks++;
    if (q_data.size() != 3) begin
      errors++; $display("FAIL sat_count: got %0d frames want 3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (q_data[i] !== exp_d[i]) begin errors++; $display("FAIL sat_data[%0d]: got %h want %h", i, q_data[i], exp_d[i]); end
        checks++; if (q_sat[i] !== 1'b1)      begin errors++; $display("FAIL sat_flag[%0d]: got %b want 1", i, q_sat[i]); end
      end
    end
  endtask

  task automatic test_idle_gaps();
    int at;
    clear_q();
    send(pack6(2, 5, 0, 0, 0, 0), 1'b0, 1'b1, at);
    idle(2);
    send(pack6(1, 4, 3, 2, 0, 0), 1'b0, 1'b1, at);
    idle(2);
    send(pack6(-2, -5, 0, 0, 0, 0), 1'b1, 1'b1, at);
    idle(8);
    checks++;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL idle_count: got %0d frames want 1", q_data.size());
    end else begin
      checks++; if (q_data[0] !== 16'd30) begin errors++; $display("FAIL idle_data: got %0d want 30", q_data[0]); end
      checks++; if (q_cyc[0] != at + 4)   begin errors++; $display("FAIL idle_latency: got %0d want 4", q_cyc[0] - at); end
    end
  endtask

  task automatic test_truncate();
    int at;
    clear_q();
    for (int i = 0; i < 6; i++) send(pack6(1, 1, 0, 0, 0, 0), (i == 5), 1'b1, at);
    idle(8);
    checks++;
    if (q_data.size() != 2) begin
      errors++; $display("FAIL trunc_count: got %0d frames want 2", q_data.size());
    end else begin
      checks++; if (q_data[0] !== 16'd4)  begin errors++; $display("FAIL trunc_data0: got %0d want 4", q_data[0]); end
      checks++; if (q_trunc[0] !== 1'b1)  begin errors++; $display("FAIL trunc_flag0: got %b want 1", q_trunc[0]); end
      checks++; if (q_data[1] !== 16'd2)  begin errors++; $display("FAIL trunc_data1: got %0d want 2", q_data[1]); end
      checks++; if (q_trunc[1] !== 1'b0)  begin errors++; $display("FAIL trunc_flag1: got %b want 0", q_trunc[1]); end
    end
    clear_q();
    for (int i = 0; i < 4; i++) send(pack6(0, 0, 1, 1, 0, 0), (i == 3), 1'b0, at);
    idle(8);
    checks++;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL lastmax_count: got %0d frames want 1", q_data.size());
    end else begin
      checks++; if (q_data[0] !== 16'd4) begin errors++; $display("FAIL lastmax_data: got %0d want 4", q_data[0]); end
      checks++; if (q_trunc[0] !== 1'b0) begin errors++; $display("FAIL lastmax_trunc: got %b want 0", q_trunc[0]); end
    end
  endtask

  task automatic test_reset_abort();
    int at;
    clear_q();
    send(pack6(1, 5, 0, 0, 0, 0), 1'b0, 1'b1, at);
    send(pack6(0, 0, 5, 1, 0, 0), 1'b0, 1'b1, at);
    @(negedge clock);
    i_valid = 1'b0;
    i_last  = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    send(pack6(0, 0, 0, 0, 7, 1), 1'b1, 1'b1, at);
    idle(8);
    checks++;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL abort_count: got %0d frames want 1", q_data.size());
    end else begin
      checks++; if (q_data[0] !== 16'd7) begin errors++; $display("FAIL abort_data: got %0d want 7", q_data[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int at, first_at;
    int a, b, s;
    logic [47:0] d;
    logic [15:0] exp_d [8];
    clear_q();
    for (int f = 0; f < 8; f++) begin
      s = 0;
      d = '0;
      for (int k = 0; k < 3; k++) begin
        a = int'($signed(8'($urandom_range(0, 255))));
        b = int'($signed(8'($urandom_range(0, 255))));
        s += a * b;
        d[16*k +: 8]     = 8'(a);
        d[16*k + 8 +: 8] = 8'(b);
      end
      exp_d[f] = clamp_s16(s);
      send(d, 1'b1, 1'b1, at);
      if (f == 0) first_at = at;
    end
    idle(8);
    checks++;
    if (q_data.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d frames want 8", q_data.size());
    end else begin
      for (int f = 0; f < 8; f++) begin
        checks++; if (q_cyc[f] != first_at + 4 + f) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", f, q_cyc[f], first_at + 4 + f); end
        checks++; if (q_data[f] !== exp_d[f])       begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", f, q_data[f], exp_d[f]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_idle_gaps();
    test_truncate();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_accum_pipe.md
# dot_accum_pipe

Pipelined, parametrised dot-product accumulator: each input beat carries 2·N_PAIRS packed words, multiplied pairwise (word 2k × word 2k+1) and summed through a registered adder tree. Beat sums accumulate over a frame into one saturated result. Successor to the combinational pair-multiply/adder-tree block:
- arbitrary (non-power-of-2) pair count;
- signed/unsigned mode;
- multi-beat accumulation;
- valid/last framing.

Sits in the datapath between the sample packer and the detector/threshold stage.

## Interface
- N_PAIRS, 4, products per beat (≥1, any integer)
- NB_DATA, 8, bits per input word
- MAX_BEATS, 16, maximum beats per frame (≥1)
- NB_OUT, 24, output width after saturation
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- i_data  in  2·N_PAIRS·NB_DATA  word w at bits [(w+1)·NB_DATA-1 -: NB_DATA]
- i_valid  in  1  beat qualifier
- i_last  in  1  final beat of frame (meaningful only with i_valid)
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled per beat
- o_data  out  NB_OUT  frame result (signed if frame mode signed, else unsigned)
- o_valid  out  1  one-cycle pulse per completed frame
- o_sat  out  1  result was clamped
- o_trunc  out  1  frame closed by MAX_BEATS, not by i_last

## Operation
- Width rules:
  - NB_PROD = 2·NB_DATA+1; operands are sign- or zero-extended to NB_DATA+1 per i_signed, so every product is exact.
  - Tree width is NB_PROD + clog2(N_PAIRS).
  - NB_ACC = tree width + clog2(MAX_BEATS). The accumulator never overflows internally.
- Stage P: N_PAIRS products registered, with valid/last/signed.
- Tree: T = clog2(N_PAIRS) registered levels.
  - At an odd-count level, the unpaired element passes through a register (delay-balanced).
  - N_PAIRS=1 gives T=0.
- Stage A (accumulator):
  - On a valid beat, acc = first_of_frame ? sum : acc+sum.
  - Beat counter increments; first_of_frame is set after reset or after any frame close.
- Frame close on a valid beat with last=1 or counter = MAX_BEATS−1:
  - o_data ← sat(acc_next), o_valid=1.
  - o_trunc=1 iff closed by the counter without last.
  - Counter clears; the next valid beat starts a new frame.
- Saturation:
  - Signed frame: clamp to [−2^(NB_OUT−1), 2^(NB_OUT−1)−1].
  - Unsigned frame: clamp to [0, 2^NB_OUT−1].
  - o_sat=1 when clamped.
  - Frame mode is the i_signed of its first beat; a mid-frame mode change only affects how that beat's operands are extended.
- Idle cycles (i_valid=0) mid-frame are allowed; acc and counter hold.
- No backpressure: the block accepts one beat per cycle unconditionally.

## Timing
- Latency: a beat at cycle t with a closing condition gives o_valid at t+T+2.
- Throughput: one beat per cycle. Back-to-back single-beat frames give o_valid every cycle.
- o_data/o_sat/o_trunc update only with o_valid and hold otherwise. o_valid is high for exactly one cycle per frame.
- Reset values:
  - o_data=0, o_valid=0, o_sat=0, o_trunc=0.
  - Acc, counter and all pipeline valids cleared.
- Reset mid-frame or with beats in flight: all in-flight beats and the partial frame are discarded with no output. The first valid beat after reset deasserts starts a new frame.
- i_last together with counter = MAX_BEATS−1: one close, o_trunc=0.

## Structure
- Package dot_accum_pkg holds:
  - width functions (NB_PROD, tree width, NB_ACC from parameters);
  - the saturation function (value, signed flag → NB_OUT result + sat flag).
- Sub-module pipelined_adder_tree:
  - parameters N_IN, NB_IN;
  - registered levels with odd-element passthrough;
  - valid/last/signed sideband delayed alongside.
- Top holds operand extension, the product stage, the accumulator, the beat counter and output registers.

## Test plan
All scenarios use N_PAIRS=3, NB_DATA=8, NB_OUT=16, MAX_BEATS=4 (T=2, latency 4).
- Signed single beat, pairs (3,4),(−2,5),(7,−1), last=1 at cycle 0 → cycle 4: o_valid=1, o_data=0xFFFB (−5), o_sat=0, o_trunc=0.
- Saturation:
  - Signed (−128,−128)×3 → 0x7FFF, o_sat=1.
  - Signed (−128,127)×3 → 0x8000, o_sat=1.
  - Unsigned (255,255)×3 → 0xFFFF, o_sat=1.
- Three beats each summing 10, with 2 idle cycles between them, last on the third → one o_valid, o_data=30; no o_valid earlier.
- Six consecutive beats each summing 1, last only on the sixth:
  - first o_valid: o_data=4, o_trunc=1;
  - second o_valid: o_data=2, o_trunc=0.
- Two beats summing 5, reset for 1 cycle, then one beat summing 7 with last → single o_valid, o_data=7; nothing emitted for the aborted frame.
- Eight back-to-back single-beat frames with random signed data → o_valid on 8 consecutive cycles starting 4 cycles after the first beat; each o_data matches the reference dot product.
